// File: rtl/spl_meter_sched_pkg.sv
// Shared types and sizing helpers for the peak-meter scheduler.
package spl_meter_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_STORE} state_e;

  function automatic int level_bits(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int ch_bits(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Level reported for silence (and for unused/reset slots): LEVEL_SILENT = WIDTH.
  function automatic int level_silent(input int width);
    return width;
  endfunction

endpackage

// File: rtl/spl_meter_sched_if.sv
// Scheduler bus: sample strobe, packed peaks, meter strobes, level readout.
// SPL_METER_SCHED_OVERRUN_EN adds the overrun counter and its clear.
interface spl_meter_sched_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  import spl_meter_sched_pkg::*;
  localparam int BITS = level_bits(WIDTH);
  localparam int CW   = ch_bits(CHANNELS);

  logic                      sample_en_i;
  logic [CHANNELS*WIDTH-1:0] peak_i;
  logic                      peak_en_o;
  logic                      decay_en_o;
  logic [CW-1:0]             rd_ch_i;
  logic [BITS-1:0]           rd_level_o;
  logic                      busy_o;
  logic                      scan_done_o;
`ifdef SPL_METER_SCHED_OVERRUN_EN
  logic [7:0]                overrun_o;
  logic                      overrun_clr_i;

  modport master (output sample_en_i, peak_i, rd_ch_i, overrun_clr_i,
                  input  peak_en_o, decay_en_o, rd_level_o, busy_o, scan_done_o, overrun_o);
  modport slave  (input  sample_en_i, peak_i, rd_ch_i, overrun_clr_i,
                  output peak_en_o, decay_en_o, rd_level_o, busy_o, scan_done_o, overrun_o);
`else
  modport master (output sample_en_i, peak_i, rd_ch_i,
                  input  peak_en_o, decay_en_o, rd_level_o, busy_o, scan_done_o);
  modport slave  (input  sample_en_i, peak_i, rd_ch_i,
                  output peak_en_o, decay_en_o, rd_level_o, busy_o, scan_done_o);
`endif
endinterface

// File: rtl/spl_meter_sched_lzc.sv
// Serial leading-zero counter: shifts left until the MSB is set or WIDTH shifts are done.
module spl_lzc_serial #(
  parameter int WIDTH = 16,
  parameter int BITS  = 5
)(
  input  logic             ck,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [BITS-1:0]  level_o,
  output logic             done_o
);
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BITS-1:0]  cnt_q, cnt_d;

  assign done_o  = shift_q[WIDTH-1] || (cnt_q == BITS'(WIDTH));
  assign level_o = cnt_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      shift_d = din_i;
      cnt_d   = '0;
    end else if (!done_o) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // Reset parks the engine in its done state so it sits still while idle.
  always_ff @(posedge ck) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= BITS'(WIDTH);
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/spl_meter_sched.sv
// Peak-meter scheduler: meter strobes, decay prescaler, serial level scan, level file.
// SPL_METER_SCHED_OVERRUN_EN adds a saturating count of dropped sample strobes.
module spl_meter_sched
  import spl_meter_sched_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int DECAY_DIV = 1024
)(
  input logic              ck,
  input logic              rst,
  spl_meter_sched_if.slave bus
);
  localparam int BITS = level_bits(WIDTH);
  localparam int CW   = ch_bits(CHANNELS);
  localparam int PW   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int DW   = 4;
  localparam logic [BITS-1:0] LEVEL_SILENT = BITS'(level_silent(WIDTH));

  state_e state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          pend_q, pend_d;
  logic          peak_en_q, decay_en_q, decay_en_d, scan_done_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          arm_q, arm_d, fire;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          busy, store, last, lzc_start, lzc_done;
  logic [BITS-1:0] lzc_level, rd_level_q, rd_level_d;
  logic [CHANNELS-1:0][BITS-1:0]  level_q;
  logic [CHANNELS-1:0][WIDTH-1:0] peak_arr;

  assign peak_arr = bus.peak_i;

  // FSM: state register
  always_ff @(posedge ck) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.sample_en_i || pend_q) state_d = S_LOAD;
      S_LOAD:  state_d = S_COUNT;
      S_COUNT: if (lzc_done) state_d = S_STORE;
      S_STORE: state_d = (ch_q == CW'(CHANNELS - 1)) ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    lzc_start = (state_q == S_LOAD);
    store     = (state_q == S_STORE);
    last      = store && (ch_q == CW'(CHANNELS - 1));
  end

  spl_lzc_serial #(.WIDTH(WIDTH), .BITS(BITS)) u_lzc (
    .ck      (ck),
    .rst     (rst),
    .start_i (lzc_start),
    .din_i   (peak_arr[ch_q]),
    .level_o (lzc_level),
    .done_o  (lzc_done)
  );

  // Channel pointer and one-deep pending request.
  always_comb begin
    ch_d   = ch_q;
    pend_d = pend_q;
    if (!busy) begin
      if (bus.sample_en_i || pend_q) begin
        pend_d = 1'b0;
        ch_d   = '0;
      end
    end else if (bus.sample_en_i) begin
      pend_d = 1'b1;
    end
    if (store && !last) ch_d = ch_q + 1'b1;
  end

  // Decay requests queue up while peak_en is busy; fire only when the next cycle has no peak_en.
  always_comb begin
    presc_d = presc_q;
    arm_d   = 1'b0;
    if (bus.sample_en_i) begin
      if (presc_q == PW'(DECAY_DIV - 1)) begin
        presc_d = '0;
        arm_d   = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    fire   = (arm_q || (dcnt_q != '0)) && !bus.sample_en_i;
    dcnt_d = dcnt_q;
    if (arm_q && !fire) begin
      if (dcnt_q != '1) dcnt_d = dcnt_q + 1'b1;
    end else if (!arm_q && fire) begin
      dcnt_d = dcnt_q - 1'b1;
    end
    decay_en_d = fire;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      ch_q        <= '0;
      pend_q      <= 1'b0;
      peak_en_q   <= 1'b0;
      decay_en_q  <= 1'b0;
      scan_done_q <= 1'b0;
      presc_q     <= '0;
      arm_q       <= 1'b0;
      dcnt_q      <= '0;
    end else begin
      ch_q        <= ch_d;
      pend_q      <= pend_d;
      peak_en_q   <= bus.sample_en_i;
      decay_en_q  <= decay_en_d;
      scan_done_q <= last;
      presc_q     <= presc_d;
      arm_q       <= arm_d;
      dcnt_q      <= dcnt_d;
    end
  end

  // Level file; a same-cycle read of the channel being stored sees the old level.
  assign rd_level_d = (int'(bus.rd_ch_i) < CHANNELS) ? level_q[bus.rd_ch_i] : LEVEL_SILENT;

  always_ff @(posedge ck) begin
    if (rst) begin
      level_q    <= {CHANNELS{LEVEL_SILENT}};
      rd_level_q <= LEVEL_SILENT;
    end else begin
      if (store) level_q[ch_q] <= lzc_level;
      rd_level_q <= rd_level_d;
    end
  end

`ifdef SPL_METER_SCHED_OVERRUN_EN
  logic       drop;
  logic [7:0] ovr_q, ovr_d;

  assign drop = bus.sample_en_i && busy && pend_q;

  always_comb begin
    ovr_d = ovr_q;
    if (bus.overrun_clr_i)              ovr_d = {7'd0, drop};
    else if (drop && (ovr_q != 8'hFF))  ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge ck) begin
    if (rst) ovr_q <= '0;
    else     ovr_q <= ovr_d;
  end

  assign bus.overrun_o = ovr_q;
`endif

  assign bus.peak_en_o   = peak_en_q;
  assign bus.decay_en_o  = decay_en_q;
  assign bus.rd_level_o  = rd_level_q;
  assign bus.busy_o      = busy;
  assign bus.scan_done_o = scan_done_q;
endmodule
